// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// with a registered per-port response slot and per-port issue counters.
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int CTRLW = 2,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [CTRLW-1:0] req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [CTRLW-1:0] req1_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_data,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [CTRLW-1:0] alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    output logic [CNTW-1:0]  issue_cnt0,
    output logic [CNTW-1:0]  issue_cnt1
);

    logic rr_ptr;
    logic elig0;
    logic elig1;
    logic grant0;
    logic grant1;

    // A port may issue when its response slot is empty or draining this cycle.
    always_comb begin
        elig0  = req0_valid && (!rsp0_valid || rsp0_ready);
        elig1  = req1_valid && (!rsp1_valid || rsp1_ready);
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_n) begin
            if (elig0 && elig1) begin
                grant0 = !rr_ptr;
                grant1 = rr_ptr;
            end else begin
                grant0 = elig0;
                grant1 = elig1;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = '0;
        if (grant0) begin
            alu_a    = req0_a;
            alu_b    = req0_b;
            alu_ctrl = req0_op;
        end else if (grant1) begin
            alu_a    = req1_a;
            alu_b    = req1_b;
            alu_ctrl = req1_op;
        end
    end

    // Result capture: a same-cycle drain and grant simply overwrites the slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_data  <= '0;
            rsp1_data  <= '0;
            issue_cnt0 <= '0;
            issue_cnt1 <= '0;
        end else begin
            if (grant0) begin
                rr_ptr <= 1'b1;
            end else if (grant1) begin
                rr_ptr <= 1'b0;
            end

            if (grant0) begin
                rsp0_data  <= alu_result;
                rsp0_valid <= 1'b1;
                issue_cnt0 <= issue_cnt0 + 1'b1;
            end else if (rsp0_valid && rsp0_ready) begin
                rsp0_valid <= 1'b0;
            end

            if (grant1) begin
                rsp1_data  <= alu_result;
                rsp1_valid <= 1'b1;
                issue_cnt1 <= issue_cnt1 + 1'b1;
            end else if (rsp1_valid && rsp1_ready) begin
                rsp1_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural ALU on the shared port.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0]  req0_op, req1_op;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready, rsp1_ready;
    logic [31:0] rsp0_data, rsp1_data;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [1:0]  alu_ctrl;
    logic [15:0] issue_cnt0, issue_cnt1;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp0[$];
    logic [31:0] exp1[$];
    logic [15:0] cnt0_exp;
    logic [15:0] cnt1_exp;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op);
        case (op)
            2'b00:   alu_f = a + b;
            2'b01:   alu_f = $signed(a) >>> b[4:0];
            2'b10:   alu_f = a & b;
            default: alu_f = a << b[4:0];
        endcase
    endfunction

    assign alu_result = alu_f(alu_a, alu_b, alu_ctrl);

    alu_arbiter #(.WIDTH(32), .CTRLW(2), .CNTW(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
        .issue_cnt0(issue_cnt0), .issue_cnt1(issue_cnt1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        #3 rst_n = 1'b1;
        tick();
        exp0.delete();
        exp1.delete();
        cnt0_exp = '0;
        cnt1_exp = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd9;
        req1_valid = 1'b1; req1_a = 32'd7; req1_b = 32'd7;
        tick();
        tick();
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready got=%b%b exp=00", req0_ready, req1_ready);
        end
        checks++;
        if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_ctrl !== 2'd0) begin
            failures++;
            $display("FAIL reset_alu got=%0d/%0d/%0d exp=0/0/0", alu_a, alu_b, alu_ctrl);
        end
        checks++;
        if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || rsp0_data !== 32'd0 || rsp1_data !== 32'd0) begin
            failures++;
            $display("FAIL reset_rsp got=%b%b %0d %0d exp=00 0 0", rsp0_valid, rsp1_valid, rsp0_data, rsp1_data);
        end
        checks++;
        if (issue_cnt0 !== 16'd0 || issue_cnt1 !== 16'd0) begin
            failures++;
            $display("FAIL reset_cnt got=%0d %0d exp=0 0", issue_cnt0, issue_cnt1);
        end
        idle_inputs();
        #3 rst_n = 1'b1;
        tick();
        exp0.delete(); exp1.delete();
        cnt0_exp = '0; cnt1_exp = '0;
    endtask

    task automatic test_contention();
        do_reset();
        req0_valid = 1'b1; req0_a = 32'd11; req0_b = 32'd5; req0_op = 2'b10;
        req1_valid = 1'b1; req1_a = 32'd10; req1_b = 32'd5; req1_op = 2'b11;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin
                failures++;
                $display("FAIL contention_grant cyc=%0d got=%b%b exp_port=%0d", i, req0_ready, req1_ready, i % 2);
            end
            if (i % 2 == 0) begin
                exp0.push_back(alu_f(32'd11, 32'd5, 2'b10));
                cnt0_exp++;
            end else begin
                exp1.push_back(alu_f(32'd10, 32'd5, 2'b11));
                cnt1_exp++;
            end
            tick();
            checks++;
            if (i % 2 == 0) begin
                if (rsp0_valid !== 1'b1 || rsp0_data !== exp0.pop_front()) begin
                    failures++;
                    $display("FAIL contention_rsp0 cyc=%0d got=%b/%0d exp=1/1", i, rsp0_valid, rsp0_data);
                end
            end else begin
                if (rsp1_valid !== 1'b1 || rsp1_data !== exp1.pop_front()) begin
                    failures++;
                    $display("FAIL contention_rsp1 cyc=%0d got=%b/%0d exp=1/320", i, rsp1_valid, rsp1_data);
                end
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        checks++;
        if (issue_cnt0 !== cnt0_exp || issue_cnt1 !== cnt1_exp) begin
            failures++;
            $display("FAIL contention_cnt got=%0d %0d exp=%0d %0d", issue_cnt0, issue_cnt1, cnt0_exp, cnt1_exp);
        end
        tick();
    endtask

    task automatic test_single();
        logic [31:0] e;
        req0_valid = 1'b1; req0_a = 32'd50; req0_b = 32'd100; req0_op = 2'b00;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || alu_a !== 32'd50 || alu_b !== 32'd100 || alu_ctrl !== 2'b00) begin
            failures++;
            $display("FAIL single_mux got=rdy%b %0d/%0d/%0d exp=rdy1 50/100/0", req0_ready, alu_a, alu_b, alu_ctrl);
        end
        exp0.push_back(32'd150);
        cnt0_exp++;
        tick();
        req0_valid = 1'b0;
        e = exp0.pop_front();
        checks++;
        if (rsp0_valid !== 1'b1 || rsp0_data !== e) begin
            failures++;
            $display("FAIL single_rsp got=%b/%0d exp=1/%0d", rsp0_valid, rsp0_data, e);
        end
        checks++;
        if (issue_cnt0 !== cnt0_exp) begin
            failures++;
            $display("FAIL single_cnt got=%0d exp=%0d", issue_cnt0, cnt0_exp);
        end
        tick();
        checks++;
        if (rsp0_valid !== 1'b0 || rsp0_data !== e) begin
            failures++;
            $display("FAIL single_drain got=%b/%0d exp=0/%0d", rsp0_valid, rsp0_data, e);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        rsp0_ready = 1'b0; rsp1_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd7; req0_b = 32'd8; req0_op = 2'b00;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_first_grant got=%b exp=1", req0_ready);
        end
        exp0.push_back(alu_f(32'd7, 32'd8, 2'b00));
        cnt0_exp++;
        tick();
        held = exp0.pop_front();
        req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd6; req1_op = 2'b10;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin
                failures++;
                $display("FAIL bp_grant cyc=%0d got=%b%b exp=01", i, req0_ready, req1_ready);
            end
            exp1.push_back(alu_f(32'd3, 32'd6, 2'b10));
            cnt1_exp++;
            tick();
            checks++;
            if (rsp1_valid !== 1'b1 || rsp1_data !== exp1.pop_front()) begin
                failures++;
                $display("FAIL bp_rsp1 cyc=%0d got=%b/%0d exp=1/2", i, rsp1_valid, rsp1_data);
            end
            checks++;
            if (rsp0_valid !== 1'b1 || rsp0_data !== held) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d got=%b/%0d exp=1/%0d", i, rsp0_valid, rsp0_data, held);
            end
        end
        rsp0_ready = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_release_grant got=%b%b exp=10", req0_ready, req1_ready);
        end
        exp0.push_back(alu_f(32'd7, 32'd8, 2'b00));
        cnt0_exp++;
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        checks++;
        if (rsp0_valid !== 1'b1 || rsp0_data !== exp0.pop_front()) begin
            failures++;
            $display("FAIL bp_release_rsp got=%b/%0d exp=1/15", rsp0_valid, rsp0_data);
        end
        checks++;
        if (issue_cnt0 !== cnt0_exp || issue_cnt1 !== cnt1_exp) begin
            failures++;
            $display("FAIL bp_cnt got=%0d %0d exp=%0d %0d", issue_cnt0, issue_cnt1, cnt0_exp, cnt1_exp);
        end
    endtask

    task automatic test_back_to_back();
        rsp0_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd3; req0_op = 2'b01;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_grant0 got=%b exp=1", req0_ready);
        end
        exp0.push_back(alu_f(32'd1, 32'd3, 2'b01));
        cnt0_exp++;
        tick();
        req0_a = 32'd2; req0_b = 32'd2; req0_op = 2'b00;
        checks++;
        if (rsp0_valid !== 1'b1 || rsp0_data !== exp0.pop_front()) begin
            failures++;
            $display("FAIL b2b_rsp_a got=%b/%0d exp=1/0", rsp0_valid, rsp0_data);
        end
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_grant1 got=%b exp=1", req0_ready);
        end
        exp0.push_back(alu_f(32'd2, 32'd2, 2'b00));
        cnt0_exp++;
        tick();
        req0_valid = 1'b0;
        checks++;
        if (rsp0_valid !== 1'b1 || rsp0_data !== exp0.pop_front()) begin
            failures++;
            $display("FAIL b2b_rsp_b got=%b/%0d exp=1/4", rsp0_valid, rsp0_data);
        end
    endtask

    task automatic test_async_reset();
        rsp0_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd5; req0_op = 2'b00;
        exp0.push_back(alu_f(32'd5, 32'd5, 2'b00));
        tick();
        req0_valid = 1'b0; rsp0_ready = 1'b0;
        checks++;
        if (rsp0_valid !== 1'b1 || rsp0_data !== exp0.pop_front()) begin
            failures++;
            $display("FAIL areset_setup got=%b/%0d exp=1/10", rsp0_valid, rsp0_data);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (rsp0_valid !== 1'b0 || rsp0_data !== 32'd0 || issue_cnt0 !== 16'd0 || issue_cnt1 !== 16'd0) begin
            failures++;
            $display("FAIL areset_clear got=%b/%0d cnt=%0d,%0d exp=0/0 cnt=0,0", rsp0_valid, rsp0_data, issue_cnt0, issue_cnt1);
        end
        exp0.delete(); exp1.delete();
        cnt0_exp = '0; cnt1_exp = '0;
        tick();
        req0_valid = 1'b1; req0_a = 32'd4; req0_b = 32'd4; req0_op = 2'b10;
        req1_valid = 1'b1; req1_a = 32'd6; req1_b = 32'd1; req1_op = 2'b00;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL areset_hold_ready got=%b%b exp=00", req0_ready, req1_ready);
        end
        #2 rst_n = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL areset_first_grant got=%b%b exp=10", req0_ready, req1_ready);
        end
        exp0.push_back(alu_f(32'd4, 32'd4, 2'b10));
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        checks++;
        if (rsp0_valid !== 1'b1 || rsp0_data !== exp0.pop_front() || rsp1_valid !== 1'b0) begin
            failures++;
            $display("FAIL areset_after got=%b/%0d rsp1v=%b exp=1/4 rsp1v=0", rsp0_valid, rsp0_data, rsp1_valid);
        end
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        rsp1_ready = 1'b1;
        req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd1; req1_op = 2'b00;
        for (int i = 0; i < 65535; i++) tick();
        checks++;
        if (issue_cnt1 !== 16'hFFFF) begin
            failures++;
            $display("FAIL wrap_max got=%0d exp=65535", issue_cnt1);
        end
        tick();
        req1_valid = 1'b0;
        checks++;
        if (issue_cnt1 !== 16'd0 || issue_cnt0 !== 16'd0) begin
            failures++;
            $display("FAIL wrap_zero got=%0d %0d exp=0 0", issue_cnt1, issue_cnt0);
        end
        checks++;
        if (rsp1_valid !== 1'b1 || rsp1_data !== 32'd2) begin
            failures++;
            $display("FAIL wrap_rsp got=%b/%0d exp=1/2", rsp1_valid, rsp1_data);
        end
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        cnt0_exp = '0;
        cnt1_exp = '0;
        test_reset();
        test_contention();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_async_reset();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter that shares the single-cycle RISC-V ALU (2-bit control: 00 add, 01 arithmetic shift, 10 and, 11 shift) between two requesters, for example the execute stage and the address-generation path. It multiplexes the granted requester's operands and control onto the ALU inputs, and captures the ALU result into a per-port response register. Each response register has its own valid/ready handshake. Per-port issue counters are provided for performance observation.

## Interface
- WIDTH, 32, operand/result width
- CTRLW, 2, ALU control width
- CNTW, 16, width of per-port issue counters
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req0_valid / req1_valid  input  1  requester i presents an operation
- req0_ready / req1_ready  output  1  arbiter accepts requester i this cycle
- req0_a, req0_b / req1_a, req1_b  input  WIDTH  operands of requester i
- req0_op / req1_op  input  CTRLW  ALU control of requester i
- rsp0_valid / rsp1_valid  output  1  response register i holds a result
- rsp0_ready / rsp1_ready  input  1  requester i consumes its response
- rsp0_data / rsp1_data  output  WIDTH  result for requester i
- alu_a, alu_b  output  WIDTH  ALU operands (combinational mux)
- alu_ctrl  output  CTRLW  ALU control (combinational mux)
- alu_result  input  WIDTH  combinational ALU result
- issue_cnt0 / issue_cnt1  output  CNTW  operations accepted from port i, wrapping

## Operation
- Eligibility: port i is eligible when reqi_valid && (!rspi_valid || rspi_ready), meaning its response slot is free or is being drained this cycle.
- Arbitration is combinational, with at most one grant per cycle:
  - If exactly one port is eligible, it is granted.
  - If both are eligible, the port selected by rr_ptr is granted.
  - If neither is eligible, there is no grant.
- reqi_ready = grant_i. A transfer occurs when reqi_valid && reqi_ready.
- rr_ptr update: after any grant to port i, rr_ptr <= the other port. rr_ptr holds its value when there is no grant.
- ALU mux:
  - alu_a/alu_b/alu_ctrl carry the granted port's req_a/req_b/req_op.
  - With no grant, they are driven to 0/0/2'b00.
- Response register i, evaluated at the clock edge:
  - On a grant: rspi_data <= alu_result and rspi_valid <= 1.
  - Else, if rspi_valid && rspi_ready: rspi_valid <= 0, and rspi_data holds its value.
  - Otherwise everything holds.
- A drain and a new grant in the same cycle: the new result replaces the old one and rspi_valid stays 1.
- issue_cnti increments by 1 on every transfer on port i. It wraps from 2^CNTW-1 to 0.
- Requester rules: operands and op must stay stable while valid && !ready. A requester may drop valid without a transfer; the arbiter does not depend on either behaviour.
- The arbiter has no ordering between ports. Within a port, responses return strictly in acceptance order, with at most one outstanding.

## Timing
- Reset (rst_n low, asynchronous): rsp0_valid=rsp1_valid=0, rsp0_data=rsp1_data=0, rr_ptr=0 (port 0 wins the first conflict), issue_cnt0=issue_cnt1=0.
- While rst_n is low, req_ready is 0 and the ALU outputs are 0.
- Reset release is synchronous to the next rising edge.
- Latency: a request accepted in cycle N has rspi_valid=1 with the result in cycle N+1.
- Throughput: one operation per cycle in aggregate.
- A single port with rsp_ready held high sustains one operation per cycle.
- Under continuous contention, grants strictly alternate 0,1,0,1…
- Backpressure: if rspi_valid=1 and rspi_ready=0, port i is ineligible and the other port may take every cycle.
- Reset mid-operation: pending responses are discarded, and no response is produced for a request accepted in the cycle of reset assertion.
- All paths from req to req_ready and to the alu_* outputs are combinational. There is no combinational path from rsp_ready to rsp_valid.

## Test plan
- Port 0 only, a=50, b=100, op=00, with the ALU model attached:
  - req0_ready=1 in cycle N and alu_a=50, alu_b=100, alu_ctrl=00.
  - Cycle N+1: rsp0_valid=1, rsp0_data=150, issue_cnt0=1.
- First cycle after reset, both ports valid (port 0: a=11, b=5, op=10; port 1: a=10, b=5, op=11), both rsp_ready=1:
  - Port 0 is granted first (rsp0_data=1 next cycle).
  - Port 1 is granted the following cycle.
  - Grants then keep alternating for 8 cycles.
- rsp0 held with rsp0_ready=0 while both ports request:
  - req0_ready stays 0.
  - Port 1 is granted every cycle.
  - rsp0_data is unchanged until rsp0_ready rises, and port 0 is granted in that same cycle.
- Port 0 back-to-back, a=1, b=3, op=01, then a=2, b=2, op=00, with rsp0_ready=1:
  - rsp0_valid stays 1 for both cycles.
  - Data updates each cycle, with no bubble.
- 65536 transfers on port 1: issue_cnt1 returns to 0, and issue_cnt0 is unaffected.
- rst_n asserted asynchronously mid-cycle with rsp0_valid=1 and rr_ptr=1:
  - Outputs clear immediately without waiting for a clock edge.
  - After release, a simultaneous request grants port 0 first.
